// File: rtl/hdmi_fetch_ctrl.sv
// Framebuffer line-fetch scheduler: turns video timing pulses into chunked memory reads,
// with a double-buffered frame base address and sticky underrun detection.
module hdmi_fetch_ctrl #(
   parameter int HRES                = 1280,
   parameter int VRES                = 720,
   parameter int NUM_BYTES_PER_PIXEL = 4,
   parameter int CHUNK_BYTES         = 256,
   parameter int ADDR_W              = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] fb_base_in,
   input  logic              fb_base_wr,
   input  logic              read_go,
   input  logic              read_next_line,
   input  logic              read_done,
   input  logic              fifo_room,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   output logic [15:0]       req_len,
   output logic              fifo_flush,
   output logic              busy,
   output logic              swap_pending,
   output logic              frame_irq,
   output logic              underrun,
   output logic [15:0]       line_idx
);

   // state     | meaning
   // IDLE      | no frame in progress, waiting for read_go with enable
   // ISSUE     | issuing the chunks of the current line
   // WAIT_LINE | line fully requested, waiting for read_next_line
   // DRAIN     | frame ended with a request in flight, waiting for its transfer

   localparam int LINE_BYTES = HRES * NUM_BYTES_PER_PIXEL;
   localparam int CPL        = LINE_BYTES / CHUNK_BYTES;
   localparam int CHUNK_W    = (CPL > 1) ? $clog2(CPL) : 1;

   localparam logic [CHUNK_W-1:0] LAST_CHUNK   = CHUNK_W'(CPL - 1);
   localparam logic [ADDR_W-1:0]  LINE_BYTES_A = ADDR_W'(LINE_BYTES);
   localparam logic [ADDR_W-1:0]  CHUNK_A      = ADDR_W'(CHUNK_BYTES);
   localparam logic [15:0]        VRES_L       = 16'(VRES);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LINE, DRAIN} state_t;

   state_t              state_q, state_d;
   logic                req_valid_q, req_valid_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [CHUNK_W-1:0]  chunk_q, chunk_d;
   logic [15:0]         line_idx_q, line_idx_d;
   logic [ADDR_W-1:0]   active_base_q, active_base_d;
   logic [ADDR_W-1:0]   pend_base_q, pend_base_d;
   logic                swap_pending_q, swap_pending_d;
   logic                underrun_q, underrun_d;
   logic                late_q, late_d;
   logic                fifo_flush_q, fifo_flush_d;
   logic                frame_irq_q, frame_irq_d;
   logic                xfer;
   logic [ADDR_W-1:0]   next_addr;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= IDLE;
         req_valid_q    <= 1'b0;
         req_addr_q     <= '0;
         chunk_q        <= '0;
         line_idx_q     <= '0;
         active_base_q  <= '0;
         pend_base_q    <= '0;
         swap_pending_q <= 1'b0;
         underrun_q     <= 1'b0;
         late_q         <= 1'b0;
         fifo_flush_q   <= 1'b0;
         frame_irq_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_valid_q    <= req_valid_d;
         req_addr_q     <= req_addr_d;
         chunk_q        <= chunk_d;
         line_idx_q     <= line_idx_d;
         active_base_q  <= active_base_d;
         pend_base_q    <= pend_base_d;
         swap_pending_q <= swap_pending_d;
         underrun_q     <= underrun_d;
         late_q         <= late_d;
         fifo_flush_q   <= fifo_flush_d;
         frame_irq_q    <= frame_irq_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      req_valid_d    = req_valid_q;
      req_addr_d     = req_addr_q;
      chunk_d        = chunk_q;
      line_idx_d     = line_idx_q;
      active_base_d  = active_base_q;
      pend_base_d    = pend_base_q;
      swap_pending_d = swap_pending_q;
      underrun_d     = underrun_q;
      late_d         = late_q;
      fifo_flush_d   = 1'b0;
      frame_irq_d    = 1'b0;
      xfer           = req_valid_q && req_ready;

      if (fb_base_wr) begin
         pend_base_d    = fb_base_in;
         swap_pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (read_go && enable) begin
               state_d      = ISSUE;
               fifo_flush_d = 1'b1;
               line_idx_d   = '0;
               chunk_d      = '0;
               late_d       = 1'b0;
               // a write landing on the start cycle wins over the older pending value
               if (fb_base_wr) begin
                  active_base_d  = fb_base_in;
                  swap_pending_d = 1'b0;
               end else if (swap_pending_q) begin
                  active_base_d  = pend_base_q;
                  swap_pending_d = 1'b0;
               end
            end
         end
         ISSUE: begin
            if (read_done) begin
               late_d = 1'b0;
               if (req_valid_q && !req_ready) begin
                  state_d = DRAIN;
               end else begin
                  state_d     = IDLE;
                  frame_irq_d = 1'b1;
               end
            end else begin
               if (read_next_line) underrun_d = 1'b1;
               if (read_next_line || late_q) begin
                  // late line: let the in-flight request finish, skip the rest of the line
                  if (!req_valid_q || xfer) begin
                     line_idx_d = line_idx_q + 16'd1;
                     chunk_d    = '0;
                     late_d     = 1'b0;
                  end else begin
                     late_d = 1'b1;
                  end
               end else if (xfer) begin
                  if (chunk_q == LAST_CHUNK) begin
                     line_idx_d = line_idx_q + 16'd1;
                     chunk_d    = '0;
                     state_d    = WAIT_LINE;
                  end else begin
                     chunk_d = chunk_q + CHUNK_W'(1);
                  end
               end
            end
         end
         WAIT_LINE: begin
            if (read_done) begin
               state_d     = IDLE;
               frame_irq_d = 1'b1;
            end else if (read_next_line && (line_idx_q < VRES_L)) begin
               state_d = ISSUE;
            end
         end
         DRAIN: begin
            if (xfer) begin
               state_d     = IDLE;
               frame_irq_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      next_addr = active_base_d + ADDR_W'(line_idx_d) * LINE_BYTES_A
                  + ADDR_W'(chunk_d) * CHUNK_A;

      if (req_valid_q && !xfer) begin
         req_valid_d = 1'b1;
      end else if ((state_d == ISSUE) && fifo_room) begin
         req_valid_d = 1'b1;
         req_addr_d  = next_addr;
      end else begin
         req_valid_d = 1'b0;
      end
   end

   always_comb begin
      req_valid    = req_valid_q;
      req_addr     = req_addr_q;
      req_len      = 16'(CHUNK_BYTES);
      fifo_flush   = fifo_flush_q;
      busy         = (state_q != IDLE);
      swap_pending = swap_pending_q;
      frame_irq    = frame_irq_q;
      underrun     = underrun_q;
      line_idx     = line_idx_q;
   end

endmodule
